// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode codes, controller state encoding and data width.
package alu_pkg;
    localparam int DATA_W = 32;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_mode_e;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/alu_req_ctrl_if.sv
// alu_req_ctrl_if: request/response handshake bundle for alu_req_ctrl.
// Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_req_ctrl_if #(parameter int TAG_W = 4);
    import alu_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [2:0]        req_mode;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_x;
    logic [TAG_W-1:0]  resp_tag;
    logic [31:0]       op_count;
`ifdef ALU_FLAGS_EN
    logic              resp_zero;
    logic              resp_neg;
    modport master (output req_valid, req_a, req_b, req_mode, req_tag, resp_ready,
                    input req_ready, resp_valid, resp_x, resp_tag, op_count, resp_zero, resp_neg);
    modport slave  (input req_valid, req_a, req_b, req_mode, req_tag, resp_ready,
                    output req_ready, resp_valid, resp_x, resp_tag, op_count, resp_zero, resp_neg);
`else
    modport master (output req_valid, req_a, req_b, req_mode, req_tag, resp_ready,
                    input req_ready, resp_valid, resp_x, resp_tag, op_count);
    modport slave  (input req_valid, req_a, req_b, req_mode, req_tag, resp_ready,
                    output req_ready, resp_valid, resp_x, resp_tag, op_count);
`endif
endinterface

// File: rtl/alu_req_ctrl_alu.sv
// ALU: combinational 32-bit ALU, eight modes; shifts use B[4:0].
module ALU
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        mode,
    output logic [DATA_W-1:0] X
);
    always_comb begin
        X = '0;
        case (mode)
            ALU_ADD: X = A + B;
            ALU_SUB: X = A - B;
            ALU_AND: X = A & B;
            ALU_OR:  X = A | B;
            ALU_XOR: X = A ^ B;
            ALU_SLL: X = A << B[4:0];
            ALU_SRL: X = A >> B[4:0];
            ALU_SRA: X = $signed(A) >>> B[4:0];
            default: X = '0;
        endcase
    end
endmodule

// File: rtl/alu_req_ctrl.sv
// alu_req_ctrl: valid/ready front-end that registers a request, runs it on one ALU
// and holds the result until consumed. Optional result flags: ALU_FLAGS_EN.
module alu_req_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_req_ctrl_if.slave bus
);
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_mode;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_x;
    logic [31:0]       r_op_count;
    logic [DATA_W-1:0] w_x;

    ALU u_alu (.A(r_a), .B(r_b), .mode(r_mode), .X(w_x));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= '0;
            r_tag      <= '0;
            r_x        <= '0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.req_valid) begin
                    r_a     <= bus.req_a;
                    r_b     <= bus.req_b;
                    r_mode  <= bus.req_mode;
                    r_tag   <= bus.req_tag;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_x     <= w_x;
                    r_state <= ST_RESP;
                end
                ST_RESP: if (bus.resp_ready) begin
                    r_op_count <= r_op_count + 32'd1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The tag register doubles as resp_tag: it cannot change until back in IDLE.
    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_x     = r_x;
    assign bus.resp_tag   = r_tag;
    assign bus.op_count   = r_op_count;

`ifdef ALU_FLAGS_EN
    logic r_zero;
    logic r_neg;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_zero <= (w_x == '0);
            r_neg  <= w_x[DATA_W-1];
        end
    end
    assign bus.resp_zero = r_zero;
    assign bus.resp_neg  = r_neg;
`endif
endmodule

// File: tb/tb_alu_req_ctrl.sv
// tb_alu_req_ctrl: directed and random requests against an arithmetic reference
// model; exercises latency, backpressure, reset abort, counter wrap and flags.
module tb_alu_req_ctrl;
    localparam int TAG_W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    logic [31:0] exp_cnt = '0;

    alu_req_ctrl_if #(.TAG_W(TAG_W)) bus ();
    alu_req_ctrl #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        longint unsigned p;
        logic [63:0] ext;
        p = 64'd1 << b[4:0];
        ext = {{32{a[31]}}, a};
        case (m)
            3'd0: return 32'(longint'(a) + longint'(b));
            3'd1: return 32'(longint'(a) - longint'(b));
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return 32'(longint'(a) * p);
            3'd6: return 32'(longint'(a) / p);
            default: return 32'(ext / p);
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic check_resp(input string tag, input logic [31:0] x, input logic [TAG_W-1:0] t);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_x"}, bus.resp_x, x);
        chk({tag, "_tag"}, 32'(bus.resp_tag), 32'(t));
`ifdef ALU_FLAGS_EN
        chk({tag, "_zero"}, 32'(bus.resp_zero), 32'(x == 0));
        chk({tag, "_neg"}, 32'(bus.resp_neg), 32'(x[31]));
`endif
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] m, input logic [TAG_W-1:0] t, input int stall);
        logic [31:0] x;
        x = ref_alu(a, b, m);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_mode = m;
        bus.req_tag = t;
        bus.resp_ready = 1'b0;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        chk({tag, "_lat1"}, 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        check_resp(tag, x, t);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_resp({tag, "_hold"}, x, t);
            chk({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        exp_cnt++;
        #1;
        bus.resp_ready = 1'b0;
        chk({tag, "_done"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_cnt"}, bus.op_count, exp_cnt);
    endtask

    initial begin
        logic [31:0] x2;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_mode = '0;
        bus.req_tag = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_x", bus.resp_x, 32'd0);
        chk("rst_tag", 32'(bus.resp_tag), 32'd0);
        chk("rst_cnt", bus.op_count, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_zero", 32'(bus.resp_zero), 32'd0);
        chk("rst_neg", 32'(bus.resp_neg), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("add", 32'h1, 32'h2, 3'd0, 4'd3, 0);
        chk("add_lit", ref_alu(32'h1, 32'h2, 3'd0), 32'h3);
        run_op("sub", 32'h20, 32'hA, 3'd1, 4'd5, 1);
        run_op("and", 32'hCC, 32'hCA, 3'd2, 4'd1, 0);
        run_op("or", 32'hCC, 32'hCA, 3'd3, 4'd2, 0);
        run_op("xor", 32'hCC, 32'hCA, 3'd4, 4'd6, 2);
        run_op("sll", 32'hCC, 32'h2, 3'd5, 4'd7, 0);
        run_op("srl", 32'hCC, 32'h2, 3'd6, 4'd8, 0);
        run_op("sra", 32'h8000_0000, 32'h4, 3'd7, 4'd9, 0);

        // Backpressure with a second request held by the requester
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a = 32'h1234_5678;
        bus.req_b = 32'h1111_1111;
        bus.req_mode = 3'd0;
        bus.req_tag = 4'hA;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_a = 32'hFFFF_0000;
        bus.req_b = 32'h0000_00FF;
        bus.req_mode = 3'd3;
        bus.req_tag = 4'hB;
        x2 = 32'hFFFF_00FF;
        @(posedge clk);
        #1;
        check_resp("bp", 32'h2345_6789, 4'hA);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_resp("bp_hold", 32'h2345_6789, 4'hA);
            chk("bp_hold_rdy", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        exp_cnt++;
        #1;
        bus.resp_ready = 1'b0;
        chk("bp_idle_rdy", 32'(bus.req_ready), 32'd1);
        chk("bp_idle_valid", 32'(bus.resp_valid), 32'd0);
        chk("bp_cnt", bus.op_count, exp_cnt);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_second_taken", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_resp("bp2", x2, 4'hB);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        exp_cnt++;
        #1;
        bus.resp_ready = 1'b0;
        chk("bp2_cnt", bus.op_count, exp_cnt);

        // Reset while in EXEC drops the response and clears the count
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a = 32'h5;
        bus.req_b = 32'h6;
        bus.req_mode = 3'd0;
        bus.req_tag = 4'h4;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = '0;
        chk("rstx_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstx_cnt", bus.op_count, 32'd0);
        chk("rstx_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.resp_ready = i[0];
            @(posedge clk);
            #1;
            chk("rstx_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("rstx_cnt_idle", bus.op_count, 32'd0);
        end
        bus.resp_ready = 1'b0;

        for (int i = 0; i < 3; i++) run_op("b2b", $urandom, $urandom, 3'(i), 4'(i), 0);
        chk("b2b_cnt3", bus.op_count, 32'd3);

        // Counter wrap from a forced preload
        @(negedge clk);
        force dut.r_op_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_op_count;
        exp_cnt = 32'hFFFF_FFFF;
        run_op("wrap", 32'h7, 32'h1, 3'd1, 4'hC, 0);
        chk("wrap_zero", bus.op_count, 32'd0);

        run_op("sub_zero", 32'h5, 32'h5, 3'd1, 4'h1, 0);
        run_op("sub_neg", 32'h0, 32'h1, 3'd1, 4'h2, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b = (i % 7 == 0) ? 32'd31 : $urandom;
            run_op("rnd", a, b, 3'($urandom_range(0, 7)), 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
